// File: rtl/gcd_frac_reduce.sv
// gcd_frac_reduce: reduces {a, b} by their gcd g using two parallel restoring dividers, one quotient bit per clock.
module gcd_frac_reduce #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3*WIDTH-1:0]   in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_err
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] xa, xb, ra, rb, qa, qb, g, ra_n, rb_n;
  logic [WIDTH:0] sa, sb;
  logic [CW-1:0] cnt;
  logic ge_a, ge_b, accept, last, g_zero;
  assign in_ready = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign accept = in_valid && in_ready;
  assign last = (cnt == CW'(WIDTH - 1));
  assign g_zero = (in_data[WIDTH-1:0] == '0);
  // Partial remainder is kept one bit wider than the divisor so the trial subtract never overflows.
  always_comb begin
    sa = {ra, xa[WIDTH-1]};
    sb = {rb, xb[WIDTH-1]};
    ge_a = sa >= {1'b0, g};
    ge_b = sb >= {1'b0, g};
    ra_n = ge_a ? WIDTH'(sa - {1'b0, g}) : sa[WIDTH-1:0];
    rb_n = ge_b ? WIDTH'(sb - {1'b0, g}) : sb[WIDTH-1:0];
    state_n = (state == IDLE) ? (accept ? (g_zero ? DONE : DIV) : IDLE) :
              (state == DIV)  ? (last ? DONE : DIV) :
                                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      xa       <= '0;
      xb       <= '0;
      ra       <= '0;
      rb       <= '0;
      qa       <= '0;
      qb       <= '0;
      g        <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && accept) begin
        {xa, xb, g} <= in_data;
        ra  <= '0;
        rb  <= '0;
        qa  <= '0;
        qb  <= '0;
        cnt <= '0;
        out_err <= g_zero;
        if (g_zero) out_data <= '0;
      end
      if (state == DIV) begin
        xa  <= {xa[WIDTH-2:0], 1'b0};
        xb  <= {xb[WIDTH-2:0], 1'b0};
        ra  <= ra_n;
        rb  <= rb_n;
        qa  <= {qa[WIDTH-2:0], ge_a};
        qb  <= {qb[WIDTH-2:0], ge_b};
        cnt <= cnt + 1'b1;
        if (last) out_data <= {qa[WIDTH-2:0], ge_a, qb[WIDTH-2:0], ge_b};
      end
    end
  end
endmodule
